// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_arbiter
//  Description : Two-source DRAM request arbiter. It tags each grant with a
//                transaction ID, routes responses back by ID, and drops stale
//                prefetch responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 256,
    parameter int ID_W         = 3,
    parameter int EPOCH_W      = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [EPOCH_W-1:0] current_epoch,

    input  logic               h_req_valid,
    output logic               h_req_ready,
    input  logic [ADDR_W-1:0]  h_req_addr,
    input  logic [15:0]        h_req_len,
    input  logic [EPOCH_W-1:0] h_req_epoch,

    input  logic               l_req_valid,
    output logic               l_req_ready,
    input  logic [ADDR_W-1:0]  l_req_addr,
    input  logic [15:0]        l_req_len,
    input  logic [EPOCH_W-1:0] l_req_epoch,

    output logic               dram_req_valid,
    input  logic               dram_req_ready,
    output logic [ADDR_W-1:0]  dram_req_addr,
    output logic [15:0]        dram_req_len,
    output logic [ID_W-1:0]    dram_req_id,
    output logic [EPOCH_W-1:0] dram_req_epoch,
    output logic               dram_req_src,

    input  logic               dram_resp_valid,
    input  logic [ID_W-1:0]    dram_resp_id,
    input  logic [EPOCH_W-1:0] dram_resp_epoch,
    input  logic [DATA_W-1:0]  dram_resp_data,
    input  logic               dram_resp_last,

    output logic               h_resp_valid,
    output logic               l_resp_valid,
    output logic [ID_W-1:0]    resp_id,
    output logic [EPOCH_W-1:0] resp_epoch,
    output logic [DATA_W-1:0]  resp_data,
    output logic               resp_last,

    output logic [ID_W:0]      outstanding,
    output logic [15:0]        stale_drops,
    output logic               err_spurious
);

    localparam int c_MAX_OUT  = 2 ** ID_W;
    localparam int c_STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = c_STARVE_W'(STARVE_LIMIT);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = {c_STARVE_W{1'b1}};
    localparam logic [c_MAX_OUT-1:0]  c_ONE        = c_MAX_OUT'(1);

    // Transaction table and starvation state
    logic [c_MAX_OUT-1:0]  r_entry_valid;
    logic [c_MAX_OUT-1:0]  r_entry_src;
    logic [c_STARVE_W-1:0] r_starve_cnt;

    // Request slot
    logic                  r_dram_req_valid;
    logic [ADDR_W-1:0]     r_dram_req_addr;
    logic [15:0]           r_dram_req_len;
    logic [ID_W-1:0]       r_dram_req_id;
    logic [EPOCH_W-1:0]    r_dram_req_epoch;
    logic                  r_dram_req_src;

    // Response stage and status
    logic                  r_h_resp_valid;
    logic                  r_l_resp_valid;
    logic [ID_W-1:0]       r_resp_id;
    logic [EPOCH_W-1:0]    r_resp_epoch;
    logic [DATA_W-1:0]     r_resp_data;
    logic                  r_resp_last;
    logic [ID_W:0]         r_outstanding;
    logic [15:0]           r_stale_drops;
    logic                  r_err_spurious;

    logic                  w_slot_free;
    logic                  w_any_free;
    logic                  w_can_grant;
    logic                  w_promote;
    logic                  w_l_wins;
    logic                  w_h_grant;
    logic                  w_l_grant;
    logic                  w_alloc;
    logic [ID_W-1:0]       w_alloc_id;
    logic [c_MAX_OUT-1:0]  w_alloc_vec;
    logic                  w_hit;
    logic                  w_hit_src;
    logic                  w_epoch_ok;
    logic                  w_free;
    logic [c_MAX_OUT-1:0]  w_free_vec;

    assign w_slot_free = !r_dram_req_valid || dram_req_ready;
    assign w_any_free  = |(~r_entry_valid);
    assign w_can_grant = w_slot_free && w_any_free;

    assign w_promote   = (STARVE_LIMIT != 0) && (r_starve_cnt >= c_STARVE_LIM);
    assign w_l_wins    = l_req_valid && (w_promote || !h_req_valid);
    assign w_h_grant   = w_can_grant && h_req_valid && !w_l_wins;
    assign w_l_grant   = w_can_grant && w_l_wins;
    assign w_alloc     = w_h_grant || w_l_grant;

    assign h_req_ready = w_h_grant;
    assign l_req_ready = w_l_grant;

    // Lowest free entry of the table as it stood at the start of the cycle
    always_comb begin
        w_alloc_id = '0;
        for (int i = c_MAX_OUT - 1; i >= 0; i--) begin
            if (!r_entry_valid[i]) begin
                w_alloc_id = ID_W'(i);
            end
        end
    end

    assign w_alloc_vec = w_alloc ? (c_ONE << w_alloc_id) : '0;

    assign w_hit       = r_entry_valid[dram_resp_id];
    assign w_hit_src   = r_entry_src[dram_resp_id];
    assign w_epoch_ok  = (dram_resp_epoch == current_epoch);
    assign w_free      = dram_resp_valid && dram_resp_last && w_hit;
    assign w_free_vec  = w_free ? (c_ONE << dram_resp_id) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry_valid <= '0;
            r_entry_src   <= '0;
            r_starve_cnt  <= '0;
            r_outstanding <= '0;
        end else begin
            r_entry_valid <= (r_entry_valid & ~w_free_vec) | w_alloc_vec;
            if (w_alloc) begin
                r_entry_src[w_alloc_id] <= w_l_grant;
            end

            if (!l_req_valid || w_l_grant) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            case ({w_alloc, w_free})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // The slot only reloads on a grant, and a grant needs the slot to drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dram_req_valid <= 1'b0;
            r_dram_req_addr  <= '0;
            r_dram_req_len   <= '0;
            r_dram_req_id    <= '0;
            r_dram_req_epoch <= '0;
            r_dram_req_src   <= 1'b0;
        end else if (w_alloc) begin
            r_dram_req_valid <= 1'b1;
            r_dram_req_addr  <= w_l_grant ? l_req_addr  : h_req_addr;
            r_dram_req_len   <= w_l_grant ? l_req_len   : h_req_len;
            r_dram_req_epoch <= w_l_grant ? l_req_epoch : h_req_epoch;
            r_dram_req_id    <= w_alloc_id;
            r_dram_req_src   <= w_l_grant;
        end else if (dram_req_ready) begin
            r_dram_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_resp_valid <= 1'b0;
            r_l_resp_valid <= 1'b0;
            r_resp_id      <= '0;
            r_resp_epoch   <= '0;
            r_resp_data    <= '0;
            r_resp_last    <= 1'b0;
            r_stale_drops  <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            r_h_resp_valid <= dram_resp_valid && w_hit && !w_hit_src;
            r_l_resp_valid <= dram_resp_valid && w_hit && w_hit_src && w_epoch_ok;
            if (dram_resp_valid) begin
                r_resp_id    <= dram_resp_id;
                r_resp_epoch <= dram_resp_epoch;
                r_resp_data  <= dram_resp_data;
                r_resp_last  <= dram_resp_last;
            end
            if (dram_resp_valid && w_hit && w_hit_src && !w_epoch_ok
                    && (r_stale_drops != 16'hFFFF)) begin
                r_stale_drops <= r_stale_drops + 16'd1;
            end
            if (dram_resp_valid && !w_hit) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    assign dram_req_valid = r_dram_req_valid;
    assign dram_req_addr  = r_dram_req_addr;
    assign dram_req_len   = r_dram_req_len;
    assign dram_req_id    = r_dram_req_id;
    assign dram_req_epoch = r_dram_req_epoch;
    assign dram_req_src   = r_dram_req_src;

    assign h_resp_valid   = r_h_resp_valid;
    assign l_resp_valid   = r_l_resp_valid;
    assign resp_id        = r_resp_id;
    assign resp_epoch     = r_resp_epoch;
    assign resp_data      = r_resp_data;
    assign resp_last      = r_resp_last;

    assign outstanding    = r_outstanding;
    assign stale_drops    = r_stale_drops;
    assign err_spurious   = r_err_spurious;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_req_arbiter
//  Description : Scoreboard bench for mem_req_arbiter with a small reference
//                model of the ID table, stale counter and spurious flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   current_epoch;
    logic         h_req_valid, h_req_ready;
    logic [31:0]  h_req_addr;
    logic [15:0]  h_req_len;
    logic [3:0]   h_req_epoch;
    logic         l_req_valid, l_req_ready;
    logic [31:0]  l_req_addr;
    logic [15:0]  l_req_len;
    logic [3:0]   l_req_epoch;
    logic         dram_req_valid, dram_req_ready;
    logic [31:0]  dram_req_addr;
    logic [15:0]  dram_req_len;
    logic [2:0]   dram_req_id;
    logic [3:0]   dram_req_epoch;
    logic         dram_req_src;
    logic         dram_resp_valid;
    logic [2:0]   dram_resp_id;
    logic [3:0]   dram_resp_epoch;
    logic [255:0] dram_resp_data;
    logic         dram_resp_last;
    logic         h_resp_valid, l_resp_valid;
    logic [2:0]   resp_id;
    logic [3:0]   resp_epoch;
    logic [255:0] resp_data;
    logic         resp_last;
    logic [3:0]   outstanding;
    logic [15:0]  stale_drops;
    logic         err_spurious;

    mem_req_arbiter dut (
        .clk(clk), .rst_n(rst_n), .current_epoch(current_epoch),
        .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_addr(h_req_addr),
        .h_req_len(h_req_len), .h_req_epoch(h_req_epoch),
        .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_addr(l_req_addr),
        .l_req_len(l_req_len), .l_req_epoch(l_req_epoch),
        .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
        .dram_req_addr(dram_req_addr), .dram_req_len(dram_req_len), .dram_req_id(dram_req_id),
        .dram_req_epoch(dram_req_epoch), .dram_req_src(dram_req_src),
        .dram_resp_valid(dram_resp_valid), .dram_resp_id(dram_resp_id),
        .dram_resp_epoch(dram_resp_epoch), .dram_resp_data(dram_resp_data),
        .dram_resp_last(dram_resp_last),
        .h_resp_valid(h_resp_valid), .l_resp_valid(l_resp_valid), .resp_id(resp_id),
        .resp_epoch(resp_epoch), .resp_data(resp_data), .resp_last(resp_last),
        .outstanding(outstanding), .stale_drops(stale_drops), .err_spurious(err_spurious)
    );

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        logic [2:0]  id;
        logic [3:0]  epoch;
        logic        src;
    } req_t;

    typedef struct {
        logic         src;
        logic [2:0]   id;
        logic [3:0]   epoch;
        logic [255:0] data;
        logic         last;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];

    int   total = 0;
    int   bad   = 0;
    logic auto_resp = 1'b0;

    logic [7:0] m_busy;
    logic [7:0] m_src;
    int         m_cnt;
    int         m_stale;
    logic       m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: table state sampled before this edge's updates
    always @(posedge clk or negedge rst_n) begin : b_model
        logic [7:0] busy0;
        logic [2:0] aid;
        req_t       r;
        resp_t      e;
        if (!rst_n) begin
            m_busy  = '0;
            m_src   = '0;
            m_cnt   = 0;
            m_stale = 0;
            m_err   = 1'b0;
            req_q.delete();
            resp_q.delete();
        end else begin
            busy0 = m_busy;
            if (dram_resp_valid) begin
                if (busy0[dram_resp_id]) begin
                    e.src = m_src[dram_resp_id]; e.id = dram_resp_id;
                    e.epoch = dram_resp_epoch; e.data = dram_resp_data; e.last = dram_resp_last;
                    if (!e.src || dram_resp_epoch == current_epoch) resp_q.push_back(e);
                    else if (m_stale < 65535) m_stale++;
                    if (dram_resp_last) begin
                        m_busy[dram_resp_id] = 1'b0;
                        m_cnt--;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
            if ((h_req_valid && h_req_ready) || (l_req_valid && l_req_ready)) begin
                aid = '0;
                for (int i = 7; i >= 0; i--) if (!busy0[i]) aid = 3'(i);
                r.src   = l_req_valid && l_req_ready;
                r.addr  = r.src ? l_req_addr  : h_req_addr;
                r.len   = r.src ? l_req_len   : h_req_len;
                r.epoch = r.src ? l_req_epoch : h_req_epoch;
                r.id    = aid;
                req_q.push_back(r);
                m_busy[aid] = 1'b1;
                m_src[aid]  = r.src;
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin : b_monitor
        req_t  r;
        resp_t e;
        if (rst_n) begin
            if (dram_req_valid && dram_req_ready) begin
                if (req_q.size() == 0) begin
                    check("req_unexpected", dram_req_valid, 1'b0);
                end else begin
                    r = req_q.pop_front();
                    check("req_addr",  dram_req_addr,  r.addr);
                    check("req_len",   dram_req_len,   r.len);
                    check("req_id",    dram_req_id,    r.id);
                    check("req_epoch", dram_req_epoch, r.epoch);
                    check("req_src",   dram_req_src,   r.src);
                end
            end
            if (h_resp_valid || l_resp_valid) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", {h_resp_valid, l_resp_valid}, 2'b00);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_h_valid", h_resp_valid, !e.src);
                    check("resp_l_valid", l_resp_valid, e.src);
                    check("resp_id",      resp_id,      e.id);
                    check("resp_epoch",   resp_epoch,   e.epoch);
                    check("resp_data",    resp_data,    e.data);
                    check("resp_last",    resp_last,    e.last);
                end
            end
            check("outstanding",  outstanding,  m_cnt);
            check("stale_drops",  stale_drops,  m_stale);
            check("err_spurious", err_spurious, m_err);
            check("one_ready",    h_req_ready & l_req_ready, 1'b0);
        end
    end

    // Advance one cycle; when auto_resp is set, retire the lowest busy ID
    task automatic step();
        logic [2:0] aid;
        @(posedge clk);
        #1;
        dram_resp_valid = 1'b0;
        dram_resp_last  = 1'b0;
        if (auto_resp && m_busy != 0) begin
            aid = '0;
            for (int i = 7; i >= 0; i--) if (m_busy[i]) aid = 3'(i);
            dram_resp_valid = 1'b1;
            dram_resp_id    = aid;
            dram_resp_epoch = current_epoch;
            dram_resp_data  = {8{29'h0, aid}};
            dram_resp_last  = 1'b1;
        end
        #1;
    endtask

    task automatic send_beat(input logic [2:0] id, input logic [3:0] ep,
                             input logic [255:0] data, input logic last);
        step();
        dram_resp_valid = 1'b1;
        dram_resp_id    = id;
        dram_resp_epoch = ep;
        dram_resp_data  = data;
        dram_resp_last  = last;
    endtask

    task automatic drain();
        auto_resp = 1'b1;
        for (int n = 0; n < 40 && m_cnt != 0; n++) step();
        auto_resp = 1'b0;
        step();
        step();
        #1;
        check("drain_outstanding", outstanding, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; current_epoch = 4'd1;
        h_req_valid = 0; h_req_addr = 0; h_req_len = 0; h_req_epoch = 0;
        l_req_valid = 0; l_req_addr = 0; l_req_len = 0; l_req_epoch = 0;
        dram_req_ready = 0; dram_resp_valid = 0; dram_resp_id = 0;
        dram_resp_epoch = 0; dram_resp_data = 0; dram_resp_last = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        #1;
        check("rst_dram_valid", dram_req_valid, 1'b0);
        check("rst_resp_valid", {h_resp_valid, l_resp_valid}, 2'b00);
        check("rst_outstanding", outstanding, 4'd0);
        check("rst_stale", stale_drops, 16'd0);
        check("rst_err", err_spurious, 1'b0);
        check("rst_resp_data", resp_data, 256'd0);

        // H and L together: H first with id 0, L next with id 1
        h_req_valid = 1; h_req_addr = 32'h100; h_req_len = 16'd64; h_req_epoch = 4'd1;
        l_req_valid = 1; l_req_addr = 32'h200; l_req_len = 16'd32; l_req_epoch = 4'd1;
        dram_req_ready = 1;
        #1;
        check("t1_h_ready", h_req_ready, 1'b1);
        check("t1_l_ready", l_req_ready, 1'b0);
        step(); h_req_valid = 0; #1;
        check("t1_l_ready2", l_req_ready, 1'b1);
        check("t1_id0", dram_req_id, 3'd0);
        check("t1_addr0", dram_req_addr, 32'h100);
        step(); l_req_valid = 0; #1;
        check("t1_id1", dram_req_id, 3'd1);
        check("t1_src1", dram_req_src, 1'b1);
        check("t1_outstanding", outstanding, 4'd2);
        send_beat(3'd0, 4'd1, {8{32'hA5A5_0000}}, 1'b1);
        send_beat(3'd1, 4'd1, {8{32'h5A5A_1111}}, 1'b1);
        step(); step(); #1;
        check("t1_freed", outstanding, 4'd0);

        // Starvation: L promoted on its 17th waiting cycle
        current_epoch = 4'd2;
        auto_resp = 1'b1;
        step();
        h_req_valid = 1; h_req_addr = 32'h1000; h_req_len = 16'd64; h_req_epoch = 4'd2;
        l_req_valid = 1; l_req_addr = 32'h2000; l_req_len = 16'd16; l_req_epoch = 4'd2;
        for (int k = 1; k <= 17; k++) begin
            #1;
            check("t2_l_ready", l_req_ready, k == 17);
            check("t2_h_ready", h_req_ready, k != 17);
            step();
            h_req_addr = h_req_addr + 32'h40;
        end
        l_req_valid = 0;
        #1;
        check("t2_h_resume", h_req_ready, 1'b1);
        step();
        h_req_valid = 0;
        drain();

        // Fill all 8 IDs, then free id 5 and see it reused
        step();
        h_req_valid = 1; h_req_addr = 32'h4000; h_req_epoch = 4'd2;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t3_h_ready", h_req_ready, 1'b1);
            step();
            h_req_addr = h_req_addr + 32'h40;
        end
        l_req_valid = 1;
        #1;
        check("t3_full_h", h_req_ready, 1'b0);
        check("t3_full_l", l_req_ready, 1'b0);
        check("t3_outstanding8", outstanding, 4'd8);
        l_req_valid = 0;
        send_beat(3'd5, 4'd2, {8{32'hC0DE_0005}}, 1'b1);
        #1;
        check("t3_same_cycle", h_req_ready, 1'b0);
        step(); #1;
        check("t3_ready_after", h_req_ready, 1'b1);
        step(); h_req_valid = 0; #1;
        check("t3_reuse_id5", dram_req_id, 3'd5);
        check("t3_req_valid", dram_req_valid, 1'b1);
        drain();

        // Stale L responses are dropped but still free the entry
        current_epoch = 4'd3;
        step();
        l_req_valid = 1; l_req_addr = 32'h300; l_req_len = 16'd64; l_req_epoch = 4'd3;
        #1;
        check("t4_l_ready", l_req_ready, 1'b1);
        step();
        l_req_valid = 0;
        current_epoch = 4'd4;
        send_beat(3'd0, 4'd3, {8{32'hBEEF_0000}}, 1'b0);
        send_beat(3'd0, 4'd3, {8{32'hBEEF_0001}}, 1'b1);
        step(); #1;
        check("t4_no_l_resp", l_resp_valid, 1'b0);
        step(); #1;
        check("t4_stale2", stale_drops, 16'd2);
        check("t4_freed", outstanding, 4'd0);

        // Beat for an unallocated ID
        send_beat(3'd6, 4'd4, {8{32'hDEAD_0006}}, 1'b1);
        step(); #1;
        check("t5_err", err_spurious, 1'b1);
        check("t5_no_resp", {h_resp_valid, l_resp_valid}, 2'b00);
        step(); step(); step(); #1;
        check("t5_err_sticky", err_spurious, 1'b1);

        // Back-pressured slot holds, then reset mid-run
        dram_req_ready = 0;
        step();
        h_req_valid = 1; h_req_addr = 32'hABC0; h_req_len = 16'd128; h_req_epoch = 4'd4;
        #1;
        check("t6_h_ready", h_req_ready, 1'b1);
        step();
        h_req_addr = 32'hDEAD0; l_req_valid = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t6_h_blocked", h_req_ready, 1'b0);
            check("t6_l_blocked", l_req_ready, 1'b0);
            check("t6_hold_valid", dram_req_valid, 1'b1);
            check("t6_hold_addr", dram_req_addr, 32'hABC0);
            check("t6_hold_len", dram_req_len, 16'd128);
            check("t6_hold_id", dram_req_id, 3'd0);
            check("t6_hold_epoch", dram_req_epoch, 4'd4);
            step();
        end
        h_req_valid = 0; l_req_valid = 0;
        rst_n = 1'b0;
        step(); #1;
        check("t6_rst_valid", dram_req_valid, 1'b0);
        check("t6_rst_addr", dram_req_addr, 32'd0);
        check("t6_rst_out", outstanding, 4'd0);
        check("t6_rst_stale", stale_drops, 16'd0);
        check("t6_rst_err", err_spurious, 1'b0);
        check("t6_rst_resp", {h_resp_valid, l_resp_valid}, 2'b00);
        rst_n = 1'b1;
        dram_req_ready = 1;
        send_beat(3'd0, 4'd4, {8{32'h0BAD_0000}}, 1'b1);
        step(); #1;
        check("t6_old_id_spurious", err_spurious, 1'b1);

        step(); step(); #1;
        check("req_q_empty", req_q.size(), 0);
        check("resp_q_empty", resp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
